ser2par_loader_4: RTL and testbench
===================================

# ser2par_loader_4

Serial-to-parallel front end that assembles a 4-bit word from a strobed serial bit stream. It drives the data and enable inputs of the downstream 4-bit enable register. Each complete frame produces a stable 4-bit word on `o_d` and a single-cycle `o_en` load strobe, so the register captures exactly one word per frame.

## Interface
- `LSB_FIRST`, default 1: 1 = first received bit lands in `o_d[0]`; 0 = first received bit lands in `o_d[3]`.

Ports:
- `i_clk`, input, 1: rising-edge clock; all state updates on this edge.
- `i_rst`, input, 1: reset, synchronous and active-high.
- `i_start`, input, 1: frame start pulse; clears the bit counter and shift register, then enters SHIFT.
- `i_bit`, input, 1: serial data bit; sampled only when `i_bit_valid` = 1.
- `i_bit_valid`, input, 1: bit strobe; one data bit is taken per high cycle while in SHIFT (or PARITY).
- `o_d`, output, 4: last completed word; connects to the register's `i_d`.
- `o_en`, output, 1: one-cycle load strobe; connects to the register's `i_en`.
- `o_busy`, output, 1: high in SHIFT and PARITY.
- `o_err`, output, 1: one-cycle parity-error pulse; constant 0 when parity is compiled out.

## Operation
- States: IDLE, SHIFT, PARITY (present only with the macro), DONE.
- Internal state: 2-bit counter `cnt`, 4-bit shift register `sr`, 4-bit output register `o_d`.
- IDLE:
  - `i_start` → SHIFT, with `cnt` = 0 and `sr` = 0.
  - `i_bit_valid` is ignored.
- SHIFT:
  - On `i_bit_valid`, shift `i_bit` into `sr` in the direction set by `LSB_FIRST`, and `cnt`++.
  - When the 4th bit is accepted (`cnt` = 3 and valid): without the macro, `o_d` ← completed word and go to DONE; with the macro, go to PARITY.
- PARITY:
  - The next valid bit is the even-parity bit, so XOR of the 4 data bits and the parity bit must be 0.
  - Parity OK: `o_d` ← word, go to DONE.
  - Parity bad: `o_err` = 1 for one cycle, `o_d` unchanged, go to IDLE.
- DONE:
  - `o_en` = 1 (decoded from state) for exactly one cycle, then go to IDLE.
  - `i_start` in DONE goes to SHIFT instead; the strobe in that cycle is still issued.
- `o_d` never shows a partial word; it changes only on a successful frame.
- Simultaneous events:
  - `i_start` in SHIFT or PARITY aborts the frame and restarts it. There is no `o_en` and no `o_err`, and `o_d` is unchanged.
  - `i_start` and `i_bit_valid` in the same cycle: start wins and the bit is discarded.
- Reset:
  - Values: state IDLE, `cnt` = 0, `sr` = 0, `o_d` = 4'h0, `o_en` = 0, `o_busy` = 0, `o_err` = 0.
  - Reset mid-frame discards the frame with no strobe.
  - Reset overrides `i_start`.

## Timing
- Latency:
  - Without the macro, `o_en` is high in the cycle after the edge that samples the 4th valid bit.
  - With the macro, the same holds for the parity bit.
  - `o_d` is valid in that same cycle and stays held afterwards. The downstream register captures on the following edge.
- `o_err` is high in the cycle after the edge that samples a bad parity bit.
- `o_busy` rises in the cycle after `i_start` and falls in the cycle after the last bit is sampled.
- Idle gaps between valid strobes are allowed, with no timeout.
- Minimum frame is 1 + 4 cycles (5 with parity), plus 1 cycle for DONE.
- Back-to-back frames are possible when `i_start` is asserted in DONE.

## Configuration
- Macro: `SER2PAR_PARITY_EN`.
- Defined: PARITY state exists. Each frame is 4 data bits plus 1 even-parity bit. A bad frame pulses `o_err` and suppresses `o_en`.
- Undefined: no PARITY state; a frame is 4 bits and `o_err` is tied to 0.

## Test plan
- Reset: hold `i_rst` for 2 cycles with `i_start` = 1 → `o_d` = 4'h0, `o_en` = 0, `o_busy` = 0, `o_err` = 0, and no state change.
- `LSB_FIRST` = 1, bits 1,0,1,1 with valid gaps of 0–3 cycles → exactly one `o_en` pulse, `o_d` = 4'hD; with `LSB_FIRST` = 0 → `o_d` = 4'hB.
- Abort: `i_start`, two bits, then `i_start` again and bits 0,1,1,0 (`LSB_FIRST` = 1) → a single `o_en`, `o_d` = 4'h6, and the earlier word is held until then.
- With the macro: data 1,0,1,1 and parity 1 → `o_en`, `o_d` = 4'hD; same data with parity 0 → `o_err` for one cycle, no `o_en`, `o_d` keeps its previous value.
- `i_start` in the DONE cycle followed by 0,0,0,1 (`LSB_FIRST` = 1) → two `o_en` pulses, with `o_d` = 4'hD then 4'h8.
- Reset asserted after 3 bits → no `o_en`, `o_d` = 4'h0, and the 4th bit after reset is ignored (IDLE).

Source files
------------

// File: rtl/ser2par_loader_4_if.sv
// rtl/ser2par_loader_4_if.sv - serial bit input and 4-bit load outputs of ser2par_loader_4
interface ser2par_loader_4_if;
    logic       i_start;
    logic       i_bit;
    logic       i_bit_valid;
    logic [3:0] o_d;
    logic       o_en;
    logic       o_busy;
    logic       o_err;

    modport master (
        output i_start, i_bit, i_bit_valid,
        input  o_d, o_en, o_busy, o_err
    );

    modport slave (
        input  i_start, i_bit, i_bit_valid,
        output o_d, o_en, o_busy, o_err
    );
endinterface

// File: rtl/ser2par_loader_4.sv
// rtl/ser2par_loader_4.sv - serial-to-parallel 4-bit word loader, optional even parity via SER2PAR_PARITY_EN
module ser2par_loader_4 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    ser2par_loader_4_if.slave bus
);

`ifdef SER2PAR_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t     state, state_d;
    logic [1:0] cnt, cnt_d;
    logic [3:0] sr, sr_d;
    logic [3:0] sr_shift;
    logic [3:0] d_q, d_d;
`ifdef SER2PAR_PARITY_EN
    logic       err_q, err_d;
`endif

    // Shift direction decides whether the first bit ends up at bit 0 or bit 3.
    assign sr_shift = LSB_FIRST ? {bus.i_bit, sr[3:1]} : {sr[2:0], bus.i_bit};

    // State, counter, shift register and output word registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            sr    <= 4'h0;
            d_q   <= 4'h0;
`ifdef SER2PAR_PARITY_EN
            err_q <= 1'b0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            sr    <= sr_d;
            d_q   <= d_d;
`ifdef SER2PAR_PARITY_EN
            err_q <= err_d;
`endif
        end
    end

    // Next-state logic; a start pulse restarts the frame from any state and discards a same-cycle bit.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sr_d    = sr;
        d_d     = d_q;
`ifdef SER2PAR_PARITY_EN
        err_d   = 1'b0;
`endif
        if (bus.i_start) begin
            state_d = SHIFT;
            cnt_d   = 2'd0;
            sr_d    = 4'h0;
        end else begin
            case (state)
                SHIFT: begin
                    if (bus.i_bit_valid) begin
                        sr_d  = sr_shift;
                        cnt_d = cnt + 2'd1;
                        if (cnt == 2'd3) begin
`ifdef SER2PAR_PARITY_EN
                            state_d = PARITY;
`else
                            d_d     = sr_shift;
                            state_d = DONE;
`endif
                        end
                    end
                end
`ifdef SER2PAR_PARITY_EN
                PARITY: begin
                    if (bus.i_bit_valid) begin
                        if ((^sr) ^ bus.i_bit) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            d_d     = sr;
                            state_d = DONE;
                        end
                    end
                end
`endif
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.o_d    = d_q;
    assign bus.o_en   = (state == DONE);
`ifdef SER2PAR_PARITY_EN
    assign bus.o_busy = (state == SHIFT) || (state == PARITY);
    assign bus.o_err  = err_q;
`else
    assign bus.o_busy = (state == SHIFT);
    assign bus.o_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ser2par_loader_4.sv
// tb/tb_ser2par_loader_4.sv - randomized self-checking bench for ser2par_loader_4 (both LSB_FIRST settings, SER2PAR_PARITY_EN aware)
module tb_ser2par_loader_4;

    logic clk;
    logic rst, start, bitv, valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ser2par_loader_4_if bus_l ();
    ser2par_loader_4_if bus_m ();

    assign bus_l.i_start     = start;
    assign bus_l.i_bit       = bitv;
    assign bus_l.i_bit_valid = valid;
    assign bus_m.i_start     = start;
    assign bus_m.i_bit       = bitv;
    assign bus_m.i_bit_valid = valid;

    ser2par_loader_4 #(.LSB_FIRST(1'b1)) dut_l (.i_clk(clk), .i_rst(rst), .bus(bus_l.slave));
    ser2par_loader_4 #(.LSB_FIRST(1'b0)) dut_m (.i_clk(clk), .i_rst(rst), .bus(bus_m.slave));

    int vecs = 0;
    int miscompares = 0;
    int en_exp = 0, err_exp = 0;
    int en_cnt_l = 0, en_cnt_m = 0, err_cnt_l = 0, err_cnt_m = 0;
    logic [3:0] held_l = 4'h0, held_m = 4'h0;
    logic [3:0] prev_l, prev_m;
    bit last_ok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected word: bit i of the frame (i = 0 first) lands at i or 3-i.
    function automatic logic [3:0] word_of(input logic [3:0] bits, input bit lsb);
        logic [3:0] w;
        w = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (lsb) w[i] = bits[i];
            else     w[3 - i] = bits[i];
        end
        return w;
    endfunction

    task automatic chk_state(input string tag, input logic en, input logic busy, input logic err);
        chk({tag, "_en_l"},   bus_l.o_en,   en);
        chk({tag, "_en_m"},   bus_m.o_en,   en);
        chk({tag, "_busy_l"}, bus_l.o_busy, busy);
        chk({tag, "_busy_m"}, bus_m.o_busy, busy);
        chk({tag, "_err_l"},  bus_l.o_err,  err);
        chk({tag, "_err_m"},  bus_m.o_err,  err);
        chk({tag, "_d_l"},    bus_l.o_d,    held_l);
        chk({tag, "_d_m"},    bus_m.o_d,    held_m);
    endtask

    // Pulse counting and "word only changes with a strobe" watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_l.o_en)  en_cnt_l++;
            if (bus_m.o_en)  en_cnt_m++;
            if (bus_l.o_err) err_cnt_l++;
            if (bus_m.o_err) err_cnt_m++;
            if (bus_l.o_d !== prev_l) chk("d_change_without_en_l", bus_l.o_en, 1'b1);
            if (bus_m.o_d !== prev_m) chk("d_change_without_en_m", bus_m.o_en, 1'b1);
        end
        prev_l = bus_l.o_d;
        prev_m = bus_m.o_d;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            start = 1'b0;
            valid = 1'($urandom % 2);
            bitv  = 1'($urandom % 2);
            tick();
            chk_state("idle", 1'b0, 1'b0, 1'b0);
        end
        valid = 1'b0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        valid = 1'($urandom % 2);
        bitv  = 1'($urandom % 2);
        tick();
        start = 1'b0;
        valid = 1'b0;
        chk_state("start", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            valid = 1'b0;
            bitv  = 1'($urandom % 2);
            tick();
            chk_state("gap", 1'b0, 1'b1, 1'b0);
        end
        valid = 1'b1;
        bitv  = b;
        tick();
        valid = 1'b0;
    endtask

    task automatic frame_body(input logic [3:0] bits, input int maxgap, input bit bad_par);
        logic par;
        for (int i = 0; i < 4; i++) begin
            send_bit(bits[i], int'($urandom_range(maxgap, 0)));
            if (i < 3) chk_state("bit", 1'b0, 1'b1, 1'b0);
        end
`ifdef SER2PAR_PARITY_EN
        chk_state("data_done", 1'b0, 1'b1, 1'b0);
        par = (^bits) ^ bad_par;
        send_bit(par, int'($urandom_range(maxgap, 0)));
        if (bad_par) begin
            err_exp++;
            last_ok = 1'b0;
            chk_state("par_bad", 1'b0, 1'b0, 1'b1);
            return;
        end
`else
        par = bad_par;
`endif
        held_l  = word_of(bits, 1'b1);
        held_m  = word_of(bits, 1'b0);
        en_exp++;
        last_ok = 1'b1;
        chk_state("done", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] fb;
        int k;
        bit bad;
        rst = 1'b1; start = 1'b1; valid = 1'b0; bitv = 1'b0;

        // Reset with start held
        tick(); chk_state("rst1", 1'b0, 1'b0, 1'b0);
        tick(); chk_state("rst2", 1'b0, 1'b0, 1'b0);
        rst = 1'b0; start = 1'b0;
        tick(); chk_state("post_rst", 1'b0, 1'b0, 1'b0);

        // Bits 1,0,1,1 with gaps
        idle(2); start_frame(); frame_body(4'b1101, 3, 1'b0);
        chk("word_lsb_first", bus_l.o_d, 4'hD);
        chk("word_msb_first", bus_m.o_d, 4'hB);

        // Abort after two bits, restart with 0,1,1,0
        idle(1); start_frame();
        send_bit(1'b0, 1); chk_state("abort_bit", 1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 0); chk_state("abort_bit", 1'b0, 1'b1, 1'b0);
        start_frame();
        frame_body(4'b0110, 2, 1'b0);
        chk("abort_word", bus_l.o_d, 4'h6);

`ifdef SER2PAR_PARITY_EN
        idle(1); start_frame(); frame_body(4'b1101, 1, 1'b1);
        chk("par_bad_hold", bus_l.o_d, 4'h6);
        idle(1); start_frame(); frame_body(4'b1101, 1, 1'b0);
        chk("par_ok_word", bus_l.o_d, 4'hD);
`endif

        // Back-to-back: start during DONE
        idle(1); start_frame(); frame_body(4'b1101, 0, 1'b0);
        start_frame(); frame_body(4'b1000, 1, 1'b0);
        chk("b2b_word", bus_l.o_d, 4'h8);

        // Reset after 3 bits, then a stray 4th bit
        idle(1); start_frame();
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1, 0); chk_state("pre_rst_bit", 1'b0, 1'b1, 1'b0);
        end
        rst = 1'b1; start = 1'b0; valid = 1'b0;
        tick();
        @(negedge clk); #1;
        rst = 1'b0;
        held_l = 4'h0; held_m = 4'h0; last_ok = 1'b0;
        chk_state("rst_mid", 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 0);
        chk_state("stray_bit", 1'b0, 1'b0, 1'b0);
        idle(1);

        // Randomized frames
        repeat (30) begin
            fb = 4'($urandom);
`ifdef SER2PAR_PARITY_EN
            bad = ($urandom % 4) == 0;
`else
            bad = 1'b0;
`endif
            if (!(last_ok && ($urandom % 2))) begin
                idle(int'($urandom_range(2, 1)));
            end
            start_frame();
            if ($urandom % 4 == 0) begin
                k = int'($urandom_range(3, 0));
                for (int i = 0; i < k; i++) begin
                    send_bit(1'($urandom % 2), int'($urandom_range(2, 0)));
                    chk_state("rand_abort_bit", 1'b0, 1'b1, 1'b0);
                end
                start_frame();
            end
            frame_body(fb, 3, bad);
        end
        idle(2);

        chk("en_count_l", en_cnt_l, en_exp);
        chk("en_count_m", en_cnt_m, en_exp);
        chk("err_count_l", err_cnt_l, err_exp);
        chk("err_count_m", err_cnt_m, err_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
